// File: rtl/cpu_ctrl_if.sv
// Control/status bundle between the multi-cycle core controller and its
// datapath/memory. The controller connects to the master modport.
interface cpu_ctrl_if;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic       mem_we;
  logic       mem_sel_data;
  logic       instr_we;
  logic       regs_we;
  logic       wb_en;
  logic       pc_en;
  logic       halted;
  logic       trap;
  logic [2:0] state;

  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, mem_sel_data, instr_we, regs_we,
           wb_en, pc_en, halted, trap, state
  );

  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, mem_sel_data, instr_we, regs_we,
           wb_en, pc_en, halted, trap, state
  );
endinterface

// File: rtl/cpu_ctrl.sv
// Multi-cycle RV32-style core controller: fetch, register read, execute,
// memory access, with sticky halt/trap and a memory wait timeout.
module cpu_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  cpu_ctrl_if.master    bus
);

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [2:0] FETCH_INSTR = 3'd0;
  localparam logic [2:0] FETCH_REGS  = 3'd1;
  localparam logic [2:0] EXECUTE     = 3'd2;
  localparam logic [2:0] MEM         = 3'd3;
  localparam logic [2:0] HALT        = 3'd4;
  localparam logic [2:0] TRAP        = 3'd5;

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALUREG = 7'b0110011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [2:0]    r_state;
  logic [2:0]    w_next;
  logic [CW-1:0] r_wait;
  logic          w_timeout;
  logic          w_mem_req;
  logic          w_is_load;
  logic          w_is_store;
  logic          w_is_wb_op;
  logic          w_instr_we;
  logic          w_regs_we;
  logic          w_wb_en;
  logic          w_pc_en;

  always_comb begin
    w_is_load  = (bus.opcode == OP_LOAD);
    w_is_store = (bus.opcode == OP_STORE);
    w_is_wb_op = (bus.opcode == OP_ALUREG) || (bus.opcode == OP_ALUIMM) ||
                 (bus.opcode == OP_LUI)    || (bus.opcode == OP_AUIPC)  ||
                 (bus.opcode == OP_JAL)    || (bus.opcode == OP_JALR);
    w_mem_req  = (r_state == FETCH_INSTR) || (r_state == MEM);
    // ready in the same cycle takes priority over the timeout
    w_timeout  = (TIMEOUT != 0) && (r_wait == CW'(TIMEOUT)) && !bus.mem_ready;
  end

  always_comb begin
    w_next     = r_state;
    w_instr_we = 1'b0;
    w_regs_we  = 1'b0;
    w_wb_en    = 1'b0;
    w_pc_en    = 1'b0;
    case (r_state)
      FETCH_INSTR: begin
        if (bus.mem_ready) begin
          w_instr_we = 1'b1;
          w_next     = FETCH_REGS;
        end else if (w_timeout) begin
          w_next = TRAP;
        end
      end
      FETCH_REGS: begin
        w_regs_we = 1'b1;
        w_next    = EXECUTE;
      end
      EXECUTE: begin
        if (bus.opcode == OP_SYSTEM) begin
          w_next = HALT;
        end else if (w_is_load || w_is_store) begin
          w_next = MEM;
        end else if (w_is_wb_op) begin
          w_wb_en = 1'b1;
          w_pc_en = 1'b1;
          w_next  = FETCH_INSTR;
        end else if (bus.opcode == OP_BRANCH) begin
          w_pc_en = 1'b1;
          w_next  = FETCH_INSTR;
        end else begin
          w_next = TRAP;
        end
      end
      MEM: begin
        if (bus.mem_ready) begin
          w_pc_en = 1'b1;
          w_wb_en = w_is_load;
          w_next  = FETCH_INSTR;
        end else if (w_timeout) begin
          w_next = TRAP;
        end
      end
      HALT:    w_next = HALT;
      TRAP:    w_next = TRAP;
      default: w_next = TRAP;
    endcase
  end

  // Any state change clears the wait counter; the only changes that enter
  // FETCH_INSTR or MEM are exactly the entries that must restart it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH_INSTR;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_wait <= '0;
      end else if (w_mem_req && !bus.mem_ready && (r_wait != '1)) begin
        r_wait <= r_wait + CW'(1);
      end
    end
  end

  always_comb begin
    bus.mem_req      = rst_n && w_mem_req;
    bus.mem_sel_data = rst_n && (r_state == MEM);
    bus.mem_we       = rst_n && (r_state == MEM) && w_is_store;
    bus.instr_we     = rst_n && w_instr_we;
    bus.regs_we      = rst_n && w_regs_we;
    bus.wb_en        = rst_n && w_wb_en;
    bus.pc_en        = rst_n && w_pc_en;
    bus.halted       = rst_n && (r_state == HALT);
    bus.trap         = rst_n && (r_state == TRAP);
    bus.state        = r_state;
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Self-checking bench for cpu_ctrl: per-cycle expected output vectors are
// queued as stimulus is applied and compared on the falling edge.
module tb_cpu_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  cpu_ctrl_if bus();

  cpu_ctrl #(.TIMEOUT(15)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ALUIMM = 7'b0010011;
  localparam logic [6:0] OP_ILLEGAL = 7'b0000000;

  localparam logic [3:0] P_NONE  = 4'b0000;
  localparam logic [3:0] P_INSTR = 4'b1000;
  localparam logic [3:0] P_REGS  = 4'b0100;
  localparam logic [3:0] P_WB_PC = 4'b0011;
  localparam logic [3:0] P_PC    = 4'b0001;

  typedef struct {
    string      tag;
    logic [11:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // {state, mem_req, mem_we, mem_sel_data, instr_we, regs_we, wb_en, pc_en, halted, trap}
  function automatic logic [11:0] expect_vec(input logic [2:0] st, input logic [6:0] opc,
                                             input logic [3:0] pulses);
    logic req, we, sel;
    req = (st == 3'd0) || (st == 3'd3);
    sel = (st == 3'd3);
    we  = (st == 3'd3) && (opc == OP_STORE);
    return {st, req, we, sel, pulses, (st == 3'd4), (st == 3'd5)};
  endfunction

  function automatic logic [11:0] observed();
    return {bus.state, bus.mem_req, bus.mem_we, bus.mem_sel_data, bus.instr_we,
            bus.regs_we, bus.wb_en, bus.pc_en, bus.halted, bus.trap};
  endfunction

  // Called just after a rising edge; leaves time just after the next one.
  task automatic step(input string tag, input logic [6:0] opc, input logic rdy,
                      input logic [2:0] st, input logic [3:0] pulses);
    exp_t e;
    bus.opcode    = opc;
    bus.mem_ready = rdy;
    sb.push_back('{tag, expect_vec(st, opc, pulses)});
    @(negedge clk);
    e = sb.pop_front();
    check(e.tag, observed(), e.v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = '0;
    #1;
    check("reset_outputs", observed(), 12'h000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Instruction fetch with a number of wait cycles, then the register read.
  task automatic fetch(input string tag, input logic [6:0] opc, input int unsigned waits);
    for (int unsigned i = 0; i < waits; i++) step({tag, "_fwait"}, opc, 1'b0, 3'd0, P_NONE);
    step({tag, "_fetch"}, opc, 1'b1, 3'd0, P_INSTR);
    step({tag, "_regs"}, opc, 1'b1, 3'd1, P_REGS);
  endtask

  logic [6:0] wb_ops[5];

  initial begin
    wb_ops[0] = 7'b0110011;
    wb_ops[1] = 7'b0110111;
    wb_ops[2] = 7'b0010111;
    wb_ops[3] = 7'b1101111;
    wb_ops[4] = 7'b1100111;

    do_reset();

    // ALU immediate, zero wait: instr_we c0, regs_we c1, wb+pc c2, fetch c3
    fetch("aluimm", OP_ALUIMM, 0);
    step("aluimm_exec", OP_ALUIMM, 1'b1, 3'd2, P_WB_PC);
    for (int unsigned k = 0; k < 5; k++) begin
      fetch("wbop", wb_ops[k], k % 2);
      step("wbop_exec", wb_ops[k], 1'b0, 3'd2, P_WB_PC);
    end

    // Load with two memory wait cycles
    fetch("load", OP_LOAD, 0);
    step("load_exec", OP_LOAD, 1'b0, 3'd2, P_NONE);
    step("load_mwait1", OP_LOAD, 1'b0, 3'd3, P_NONE);
    step("load_mwait2", OP_LOAD, 1'b0, 3'd3, P_NONE);
    step("load_mdone", OP_LOAD, 1'b1, 3'd3, P_WB_PC);

    fetch("store", OP_STORE, 0);
    step("store_exec", OP_STORE, 1'b0, 3'd2, P_NONE);
    step("store_mdone", OP_STORE, 1'b1, 3'd3, P_PC);

    fetch("branch", OP_BRANCH, 0);
    step("branch_exec", OP_BRANCH, 1'b1, 3'd2, P_PC);

    // Reset asserted in the middle of a memory access that is completing
    fetch("rstmem", OP_LOAD, 0);
    step("rstmem_exec", OP_LOAD, 1'b0, 3'd2, P_NONE);
    bus.mem_ready = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem", observed(), 12'h000);
    do_reset();
    step("refetch", OP_LOAD, 1'b1, 3'd0, P_INSTR);

    // Fetch timeout: 16 request cycles without ready, then sticky trap
    do_reset();
    for (int unsigned i = 0; i < 16; i++) step("to_wait", OP_ALUIMM, 1'b0, 3'd0, P_NONE);
    for (int unsigned i = 0; i < 6; i++) step("to_trap", OP_ALUIMM, 1'(i % 2), 3'd5, P_NONE);

    // Ready on the last allowed wait cycle still completes; then illegal opcode
    do_reset();
    fetch("lastwait", OP_ILLEGAL, 15);
    step("illegal_exec", OP_ILLEGAL, 1'b0, 3'd2, P_NONE);
    step("illegal_trap", OP_ILLEGAL, 1'b1, 3'd5, P_NONE);

    // ebreak halts and stays halted regardless of mem_ready
    do_reset();
    fetch("system", OP_SYSTEM, 0);
    step("system_exec", OP_SYSTEM, 1'b1, 3'd2, P_NONE);
    for (int unsigned i = 0; i < 20; i++) step("halted", OP_SYSTEM, 1'(i % 2), 3'd4, P_NONE);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
CPU_CTRL -- requirements
Module: cpu_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 15, max cycles a memory request may wait for mem_ready before trapping; 0 disables timeout.
REQ-002 Port: clk  input  1  single system clock; all state changes on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: opcode  input  7  instr[6:0] from datapath instruction register; stable from FETCH_REGS until the next FETCH_INSTR.
REQ-005 Port: mem_ready  input  1  memory completes the outstanding request in this cycle.
REQ-006 Port: mem_req  output  1  memory request; held high until mem_ready.
REQ-007 Port: mem_we  output  1  request is a write (store).
REQ-008 Port: mem_sel_data  output  1  address mux select: 0 = PC, 1 = load/store address.
REQ-009 Port: instr_we  output  1  one-cycle pulse; datapath latches the instruction word.
REQ-010 Port: regs_we  output  1  one-cycle pulse; datapath latches rs1/rs2 from the register bank.
REQ-011 Port: wb_en  output  1  one-cycle register-bank write enable (rd==x0 suppression stays in datapath).
REQ-012 Port: pc_en  output  1  one-cycle pulse; datapath loads next PC.
REQ-013 Port: halted  output  1  core stopped on SYSTEM (ebreak); sticky.
REQ-014 Port: trap  output  1  core stopped on illegal opcode or memory timeout; sticky.
REQ-015 Port: state  output  3  current state encoding, for LEDs/debug.

Function
REQ-016 States/encodings SHALL be FETCH_INSTR=0, FETCH_REGS=1, EXECUTE=2, MEM=3, HALT=4, TRAP=5; encodings 6-7 SHALL go to TRAP.
REQ-017 mem_req, mem_we, mem_sel_data, halted, trap SHALL be Moore outputs; instr_we, regs_we, wb_en, pc_en SHALL be Mealy single-cycle pulses.
REQ-018 FETCH_INSTR: mem_req=1, mem_sel_data=0, mem_we=0; on mem_ready: instr_we=1, next FETCH_REGS; else remain.
REQ-019 FETCH_REGS: regs_we=1 for exactly one cycle; next EXECUTE.
REQ-020 EXECUTE, opcode 1110011 (SYSTEM): no pc_en, no wb_en; next HALT.
REQ-021 EXECUTE, opcode 0000011 (LOAD) or 0100011 (STORE): no pc_en, no wb_en; next MEM.
REQ-022 EXECUTE, opcode 0110011, 0010011, 0110111, 0010111, 1101111, 1100111 (ALUreg/ALUimm/LUI/AUIPC/JAL/JALR): wb_en=1, pc_en=1; next FETCH_INSTR.
REQ-023 EXECUTE, opcode 1100011 (BRANCH): pc_en=1, wb_en=0; next FETCH_INSTR.
REQ-024 EXECUTE, any other opcode: no pulses; next TRAP.
REQ-025 MEM: mem_req=1, mem_sel_data=1, mem_we=1 iff opcode is STORE; on mem_ready: pc_en=1, wb_en=1 iff LOAD, next FETCH_INSTR.
REQ-026 Wait counter SHALL be $clog2(TIMEOUT+1) bits, cleared on every entry to FETCH_INSTR or MEM, incremented each cycle mem_req=1 and mem_ready=0, saturating.
REQ-027 If TIMEOUT>0 and counter equals TIMEOUT while mem_ready=0, next state SHALL be TRAP; mem_ready in the same cycle wins over timeout.
REQ-028 HALT and TRAP SHALL be absorbing until reset; all pulses 0, mem_req 0; mem_ready ignored.
REQ-029 Latency: ALU instruction with zero-wait memory = 3 cycles; load/store with zero-wait memory = 4 cycles; each memory wait cycle adds 1.
REQ-030 mem_ready outside FETCH_INSTR/MEM SHALL be ignored.

Reset
REQ-031 rst_n low SHALL asynchronously force state=FETCH_INSTR, counter=0, halted=0, trap=0.
REQ-032 While rst_n low all outputs SHALL be 0 (mem_req gated by rst_n); state output SHALL read 0.
REQ-033 Reset asserted mid-request SHALL abandon the request without any pulse; first cycle after release SHALL issue a fresh instruction fetch.

Verification
REQ-034 Zero-wait memory, opcode 0010011 -> instr_we@c0, regs_we@c1, wb_en+pc_en@c2, mem_req high again @c3.
REQ-035 opcode 0000011, mem_ready delayed 2 cycles in MEM -> mem_sel_data=1, mem_we=0 for 3 cycles, then wb_en=1 and pc_en=1 same cycle.
REQ-036 opcode 0100011 -> mem_we=1 in MEM, on ready pc_en=1, wb_en=0.
REQ-037 opcode 1110011 -> state=4, halted=1, no pc_en; 20 further cycles with mem_ready toggling -> unchanged.
REQ-038 TIMEOUT=15, mem_ready held 0 in FETCH_INSTR -> state=5, trap=1 after 16 request cycles; opcode 0000000 in EXECUTE -> trap next cycle.
REQ-039 rst_n pulsed low mid-MEM -> outputs 0 immediately, no wb_en/pc_en, fetch restarts with mem_sel_data=0.
